// File: rtl/fir_output_stage_pkg.sv
// Shared defaults and saturation helpers for the FIR output path.
// Used by the output stage, its interface and its testbench.
package fir_output_stage_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int SAT_CNT_WIDTH  = 16;

  typedef logic [SAT_CNT_WIDTH-1:0] sat_count_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_output_stage_if.sv
// Valid/ready links of the output stage: FIR core -> stage (iv_din side), stage -> sink (ov_dout side).
// The slave modport is the stage; the master modport is whoever drives both links.
interface fir_output_stage_if
  import fir_output_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
);
  logic signed [DATA_WIDTH-1:0] iv_din;
  logic                         i_din_valid;
  logic                         o_ready;
  logic signed [OUT_WIDTH-1:0]  ov_dout;
  logic                         o_dout_valid;
  logic                         i_ready;

  modport slave (
    input  iv_din, i_din_valid, i_ready,
    output o_ready, ov_dout, o_dout_valid
  );

  modport master (
    output iv_din, i_din_valid, i_ready,
    input  o_ready, ov_dout, o_dout_valid
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is on dout whenever empty is low.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= din;
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fir_output_stage.sv
// FIR output conditioning: decimate, round half up, saturate to OUT_WIDTH, buffer in a FWFT FIFO.
// Latency from input accept to FIFO head is two cycles.
module fir_output_stage
  import fir_output_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter int SHIFT        = 8,
  parameter int DECIM_FACTOR = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  fir_output_stage_if.slave bus,
  output logic         o_sat,
  output sat_count_t   ov_sat_count
);
  localparam int CNT_W  = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DECIM_FACTOR - 1);
  localparam logic signed [DATA_WIDTH:0] SAT_HI  = (DATA_WIDTH + 1)'(sat_max(OUT_WIDTH));
  localparam logic signed [DATA_WIDTH:0] SAT_LO  = (DATA_WIDTH + 1)'(sat_min(OUT_WIDTH));
  localparam logic signed [DATA_WIDTH:0] ROUND_K = (DATA_WIDTH + 1)'(longint'(1) <<< (SHIFT - 1));

  logic [CNT_W-1:0]            r_decim_cnt;
  logic                        r_stage_valid;
  logic signed [OUT_WIDTH-1:0] r_stage_data;
  logic                        r_sat;
  sat_count_t                  r_sat_count;

  logic                        w_accept;
  logic                        w_keep;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [FCNT_W-1:0]           w_fifo_count;
  logic [FCNT_W:0]             w_occupancy;
  logic signed [DATA_WIDTH:0]  w_ext;
  logic signed [DATA_WIDTH:0]  w_sum;
  logic signed [DATA_WIDTH:0]  w_shifted;
  logic signed [OUT_WIDTH-1:0] w_result;
  logic                        w_clamp;

  // The stage register holds a reserved FIFO slot, so it never has to stall.
  assign w_occupancy  = {1'b0, w_fifo_count} + {{FCNT_W{1'b0}}, r_stage_valid};
  assign bus.o_ready  = ~i_rst & (w_occupancy < (FCNT_W + 1)'(FIFO_DEPTH));

  assign w_accept = i_en & bus.i_din_valid & bus.o_ready;
  assign w_keep   = w_accept & (r_decim_cnt == '0);
  assign w_push   = i_en & r_stage_valid;
  assign w_pop    = i_en & bus.o_dout_valid & bus.i_ready;

  assign w_ext     = {bus.iv_din[DATA_WIDTH-1], bus.iv_din};
  assign w_sum     = w_ext + ROUND_K;
  assign w_shifted = w_sum >>> SHIFT;

  always_comb begin
    w_clamp  = 1'b0;
    w_result = w_shifted[OUT_WIDTH-1:0];
    if (w_shifted > SAT_HI) begin
      w_result = OUT_WIDTH'(SAT_HI);
      w_clamp  = 1'b1;
    end else if (w_shifted < SAT_LO) begin
      w_result = OUT_WIDTH'(SAT_LO);
      w_clamp  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_decim_cnt   <= '0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_sat         <= 1'b0;
      r_sat_count   <= '0;
    end else if (i_en) begin
      if (w_accept) r_decim_cnt <= (r_decim_cnt == CNT_LAST) ? '0 : r_decim_cnt + 1'b1;
      r_stage_valid <= w_keep;
      r_sat         <= w_keep & w_clamp;
      if (w_keep) r_stage_data <= w_result;
      if (w_keep && w_clamp && (r_sat_count != '1)) r_sat_count <= r_sat_count + 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .wr_en (w_push),
    .din   (r_stage_data),
    .full  (w_fifo_full),
    .rd_en (w_pop),
    .dout  (bus.ov_dout),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign bus.o_dout_valid = ~w_fifo_empty;
  assign o_sat            = r_sat;
  assign ov_sat_count     = r_sat_count;

  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst) !(w_push && w_fifo_full));
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(w_pop && w_fifo_empty));

endmodule
